// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the CPU datapath.
// Sequences each instruction through IF/ID/EXE/MEM/WB and drives the datapath
// control lines from the current state and opcode. Loads and stores wait in
// MEM for mem_ready. If mem_ready stays low for WAIT_MAX cycles the unit sets
// the sticky mem_err flag and parks in HALT.
module multicycle_control_unit #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Ins,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       ExtSel,
  output logic       ALUSrcB,
  output logic       PCSrc,
  output logic [2:0] ALUOp,
  output logic       RD,
  output logic       WR,
  output logic       DBDataSrc,
  output logic       RegWre,
  output logic       RegDst,
  output logic [2:0] state,
  output logic       halted,
  output logic       illegal,
  output logic       mem_err
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADDU  = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b000001;
  localparam logic [5:0] OP_SUBU  = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_OR    = 6'b010010;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_BNE   = 6'b110000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // This is the last count at which a MEM wait may still end without a timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;

  // Opcode decode.
  logic [2:0] dec_alu_op;
  logic       dec_srcb, dec_ext, dec_rtype, dec_lw, dec_sw, dec_bne, dec_halt, dec_legal;

  // Decode the opcode into ALU controls and instruction-class flags.
  always_comb begin
    dec_alu_op = 3'b000;
    dec_srcb   = 1'b0;
    dec_ext    = 1'b0;
    dec_rtype  = 1'b0;
    dec_lw     = 1'b0;
    dec_sw     = 1'b0;
    dec_bne    = 1'b0;
    dec_halt   = 1'b0;
    dec_legal  = 1'b1;
    case (Ins)
      OP_ADDU:  dec_rtype = 1'b1;
      OP_ADDIU: dec_srcb  = 1'b1;
      OP_SUBU:  begin dec_rtype = 1'b1; dec_alu_op = 3'b001; end
      OP_ORI:   begin dec_srcb  = 1'b1; dec_alu_op = 3'b011; end
      OP_AND:   begin dec_rtype = 1'b1; dec_alu_op = 3'b100; end
      OP_OR:    begin dec_rtype = 1'b1; dec_alu_op = 3'b011; end
      OP_SW:    begin dec_sw = 1'b1; dec_srcb = 1'b1; dec_ext = 1'b1; end
      OP_LW:    begin dec_lw = 1'b1; dec_srcb = 1'b1; dec_ext = 1'b1; end
      OP_BNE:   begin dec_bne = 1'b1; dec_ext = 1'b1; dec_alu_op = 3'b001; end
      OP_HALT:  dec_halt  = 1'b1;
      default:  dec_legal = 1'b0;
    endcase
  end

  // Compute the next state and the control outputs.
  // While Reset is low, every output is held at its inactive value so that no
  // write enable can glitch high during reset.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b1;
    ExtSel    = 1'b0;
    ALUSrcB   = 1'b0;
    PCSrc     = 1'b0;
    ALUOp     = 3'b000;
    RD        = 1'b1;
    WR        = 1'b1;
    DBDataSrc = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    if (Reset) begin
      case (state_q)
        S_IF: begin
          InsMemRW = 1'b1;
          IRWre    = 1'b1;
          state_d  = S_ID;
        end
        S_ID: begin
          if (dec_halt) begin
            state_d = S_HALT;
          end else if (!dec_legal) begin
            // Skip the undefined instruction and fetch the next one.
            illegal = 1'b1;
            PCWre   = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_EXE;
          end
        end
        S_EXE: begin
          ALUOp   = dec_alu_op;
          ALUSrcB = dec_srcb;
          ExtSel  = dec_ext;
          if (dec_bne) begin
            PCSrc   = ~zero;
            PCWre   = 1'b1;
            state_d = S_IF;
          end else if (dec_lw || dec_sw) begin
            cnt_d   = '0;
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          ALUOp   = dec_alu_op;
          ALUSrcB = dec_srcb;
          ExtSel  = dec_ext;
          RD      = ~dec_lw;
          WR      = ~dec_sw;
          if (mem_ready) begin
            if (dec_sw) begin
              PCWre   = 1'b1;
              state_d = S_IF;
            end else begin
              state_d = S_WB;
            end
          end else if (cnt_q == CNT_LAST) begin
            mem_err_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WB: begin
          ALUOp     = dec_alu_op;
          ALUSrcB   = dec_srcb;
          ExtSel    = dec_ext;
          RegWre    = 1'b1;
          RegDst    = dec_rtype;
          DBDataSrc = dec_lw;
          PCWre     = 1'b1;
          state_d   = S_IF;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_d = S_IF;
        end
      endcase
    end
  end

  // State, wait counter and sticky error flag; reset aborts any instruction.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IF;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign state   = state_q;
  assign mem_err = mem_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit. The stimulus drives each cycle
// and queues the hand-computed control word expected for that cycle. The
// monitor pops the queue and compares on the falling clock edge. It can also
// be triggered immediately to check behaviour between edges, such as during an
// asynchronous reset.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] Ins = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWre, IRWre, InsMemRW, ExtSel, ALUSrcB, PCSrc;
  logic [2:0] ALUOp;
  logic       RD, WR, DBDataSrc, RegWre, RegDst;
  logic [2:0] state;
  logic       halted, illegal, mem_err;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre, irwre, imrw, ext, srcb, pcsrc;
    logic [2:0] aluop;
    logic       rd, wr, dbs, regwre, regdst, halted, illegal, merr;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  exp;
  } sb_t;

  localparam logic [5:0] ADDU = 6'b000000, ORI = 6'b010000, SW = 6'b100110;
  localparam logic [5:0] LW = 6'b100111, BNE = 6'b110000, HLT = 6'b111111, BAD = 6'b001111;

  sb_t  sbq[$];
  int   ncmp = 0;
  int   nmis = 0;
  event chk_ev;

  multicycle_control_unit #(.WAIT_MAX(15), .CNT_W(8)) dut (
    .CLK(CLK), .Reset(Reset), .Ins(Ins), .zero(zero), .mem_ready(mem_ready),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp), .RD(RD), .WR(WR),
    .DBDataSrc(DBDataSrc), .RegWre(RegWre), .RegDst(RegDst), .state(state),
    .halted(halted), .illegal(illegal), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  // Inactive control word for a given state; callers set the active fields.
  function automatic ctl_t mk(input logic [2:0] st);
    ctl_t c;
    c      = '0;
    c.st   = st;
    c.imrw = 1'b1;
    c.rd   = 1'b1;
    c.wr   = 1'b1;
    return c;
  endfunction

  task automatic push(input string tag, input ctl_t e);
    sb_t it;
    it.tag = tag;
    it.exp = e;
    sbq.push_back(it);
  endtask

  task automatic push_now(input string tag, input ctl_t e);
    push(tag, e);
    -> chk_ev;
  endtask

  // One clock cycle: drive the inputs just after the edge and queue the expected word.
  task automatic step(input string tag, input ctl_t e, input logic [5:0] ins,
                      input logic z, input logic mr);
    @(posedge CLK);
    #1;
    Ins       = ins;
    zero      = z;
    mem_ready = mr;
    push(tag, e);
  endtask

  // Pull Reset low just after an edge and hold it across one edge.
  // Release it mid-cycle, so that cycle is the IF of the next instruction.
  task automatic reset_into_if(input logic [5:0] ins);
    ctl_t e;
    @(posedge CLK);
    #1;
    Reset     = 1'b0;
    Ins       = ins;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #1;
    push_now("reset immediate", mk(3'd0));
    @(posedge CLK);
    #1;
    push_now("reset held", mk(3'd0));
    #2;
    Reset = 1'b1;
    e = mk(3'd0); e.irwre = 1'b1;
    push("IF after reset", e);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    sb_t  it;
    ctl_t got;
    forever begin
      @(negedge CLK or chk_ev);
      if (sbq.size() > 0) begin
        it = sbq.pop_front();
        got = '{st: state, pcwre: PCWre, irwre: IRWre, imrw: InsMemRW, ext: ExtSel,
                srcb: ALUSrcB, pcsrc: PCSrc, aluop: ALUOp, rd: RD, wr: WR,
                dbs: DBDataSrc, regwre: RegWre, regdst: RegDst, halted: halted,
                illegal: illegal, merr: mem_err};
        ncmp++;
        if (got !== it.exp) begin
          nmis++;
          $display("FAIL %s: got %b want %b (st|pcwre irwre imrw ext srcb pcsrc|aluop|rd wr dbs regwre regdst halted illegal merr)",
                   it.tag, got, it.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t e;
    // Reset, then addu: IF ID EXE WB
    reset_into_if(ADDU);
    step("addu ID", mk(3'd1), ADDU, 1'b0, 1'b0);
    step("addu EXE", mk(3'd2), ADDU, 1'b0, 1'b0);
    e = mk(3'd4); e.regwre = 1'b1; e.regdst = 1'b1; e.pcwre = 1'b1;
    step("addu WB", e, ADDU, 1'b0, 1'b0);

    // lw with two wait cycles; mem_ready high outside MEM must be ignored
    e = mk(3'd0); e.irwre = 1'b1;
    step("lw IF", e, LW, 1'b0, 1'b1);
    step("lw ID", mk(3'd1), LW, 1'b0, 1'b1);
    e = mk(3'd2); e.ext = 1'b1; e.srcb = 1'b1;
    step("lw EXE", e, LW, 1'b0, 1'b1);
    e = mk(3'd3); e.ext = 1'b1; e.srcb = 1'b1; e.rd = 1'b0;
    step("lw MEM wait0", e, LW, 1'b0, 1'b0);
    step("lw MEM wait1", e, LW, 1'b0, 1'b0);
    step("lw MEM ready", e, LW, 1'b0, 1'b1);
    e = mk(3'd4); e.ext = 1'b1; e.srcb = 1'b1; e.regwre = 1'b1; e.dbs = 1'b1; e.pcwre = 1'b1;
    step("lw WB", e, LW, 1'b0, 1'b0);

    // bne taken (zero=0) and not taken (zero=1)
    for (int k = 0; k < 2; k++) begin
      e = mk(3'd0); e.irwre = 1'b1;
      step("bne IF", e, BNE, k[0], 1'b0);
      step("bne ID", mk(3'd1), BNE, k[0], 1'b0);
      e = mk(3'd2); e.ext = 1'b1; e.aluop = 3'b001; e.pcwre = 1'b1; e.pcsrc = (k == 0);
      step(k == 0 ? "bne EXE zero0" : "bne EXE zero1", e, BNE, k[0], 1'b0);
    end

    // ori: I-type ALU op with zero-extended immediate
    e = mk(3'd0); e.irwre = 1'b1;
    step("ori IF", e, ORI, 1'b0, 1'b0);
    step("ori ID", mk(3'd1), ORI, 1'b0, 1'b0);
    e = mk(3'd2); e.aluop = 3'b011; e.srcb = 1'b1;
    step("ori EXE", e, ORI, 1'b0, 1'b0);
    e = mk(3'd4); e.aluop = 3'b011; e.srcb = 1'b1; e.regwre = 1'b1; e.pcwre = 1'b1;
    step("ori WB", e, ORI, 1'b0, 1'b0);

    // illegal opcode: pulse in ID, then straight back to IF
    e = mk(3'd0); e.irwre = 1'b1;
    step("illegal IF", e, BAD, 1'b0, 1'b0);
    e = mk(3'd1); e.illegal = 1'b1; e.pcwre = 1'b1;
    step("illegal ID", e, BAD, 1'b0, 1'b0);

    // sw aborted by reset in MEM
    e = mk(3'd0); e.irwre = 1'b1;
    step("sw IF", e, SW, 1'b0, 1'b0);
    step("sw ID", mk(3'd1), SW, 1'b0, 1'b0);
    e = mk(3'd2); e.ext = 1'b1; e.srcb = 1'b1;
    step("sw EXE", e, SW, 1'b0, 1'b0);
    e = mk(3'd3); e.ext = 1'b1; e.srcb = 1'b1; e.wr = 1'b0;
    step("sw MEM", e, SW, 1'b0, 1'b0);
    reset_into_if(SW);

    // sw timeout: 15 MEM cycles, then HALT with mem_err for 21 cycles
    step("swto ID", mk(3'd1), SW, 1'b0, 1'b0);
    e = mk(3'd2); e.ext = 1'b1; e.srcb = 1'b1;
    step("swto EXE", e, SW, 1'b0, 1'b0);
    e = mk(3'd3); e.ext = 1'b1; e.srcb = 1'b1; e.wr = 1'b0;
    for (int i = 0; i < 15; i++) step($sformatf("swto MEM %0d", i), e, SW, 1'b0, 1'b0);
    e = mk(3'd7); e.halted = 1'b1; e.merr = 1'b1;
    for (int i = 0; i < 21; i++) step($sformatf("swto HALT %0d", i), e, SW, 1'b0, 1'b1);

    // Reset clears mem_err; then halt instruction reaches HALT on its 3rd cycle
    reset_into_if(HLT);
    step("halt ID", mk(3'd1), HLT, 1'b0, 1'b0);
    e = mk(3'd7); e.halted = 1'b1;
    for (int i = 0; i < 5; i++) step($sformatf("halt HALT %0d", i), e, HLT, 1'b0, 1'b0);

    @(negedge CLK);
    #1;
    ncmp++;
    if (sbq.size() != 0) begin
      nmis++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
